// File: rtl/game_pkg.sv
// Shared definitions for the game controller: state encoding, score width,
// default timing/lives values and a counter-width helper.
package game_pkg;

    typedef enum logic [1:0] {
        ST_ATTRACT = 2'd0,
        ST_PLAY    = 2'd1,
        ST_DYING   = 2'd2,
        ST_OVER    = 2'd3
    } game_state_t;

    localparam int BCD_W = 16;  // four BCD digits

    localparam int DEF_LIVES        = 3;
    localparam int DEF_SCORE_DIV    = 60;
    localparam int DEF_DYING_FRAMES = 120;
    localparam int DEF_OVER_FRAMES  = 600;

    // $clog2 of a terminal count, but never narrower than one bit so a
    // parameter of 1 still yields a legal counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter that saturates at 9999.
// Ports:
//   clk_pix  pixel clock
//   rst_pix  synchronous active-high reset (count -> 0)
//   clr      synchronous clear (count -> 0)
//   en       increment by one this cycle (ignored at 9999)
//   count    current BCD value, digit 3 in [15:12]
module bcd_counter4
    import game_pkg::*;
(
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] count
);

    localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

    logic [BCD_W-1:0] count_inc;
    logic             carry;

    // Ripple a +1 through the digits: a 9 becomes 0 and passes the carry on,
    // the first non-9 digit absorbs it.
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_inc = count;
        carry     = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (count[4*d +: 4] == 4'd9) begin
                    count_inc[4*d +: 4] = 4'd0;
                end else begin
                    count_inc[4*d +: 4] = count[4*d +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; the reset is synchronous, inside the clocked
    // branch, and has priority over everything else.
    always_ff @(posedge clk_pix) begin
        if (rst_pix || clr) begin
            count <= '0;
        end else if (en && (count != BCD_MAX)) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: attract screen, play with score ticking, dying
// animation dwell, game-over dwell, lives and best-score tracking.
// Ports:
//   clk_pix    pixel clock (only clock)
//   rst_pix    synchronous active-high reset
//   frame      one-cycle pulse at the start of each video frame
//   btn_start  start button level (sampled on frame cycles only)
//   hit        player/obstacle collision level, any cycle
//   state      current state (ATTRACT=0, PLAY=1, DYING=2, OVER=3)
//   run        sprite motion enable
//   respawn    one-cycle pulse to reset player/obstacle positions
//   lives      remaining lives
//   score      4-digit BCD score
//   hiscore    4-digit BCD best score
//   new_hi     last finished game set a new best score
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES        = DEF_LIVES,
    parameter int SCORE_DIV    = DEF_SCORE_DIV,
    parameter int DYING_FRAMES = DEF_DYING_FRAMES,
    parameter int OVER_FRAMES  = DEF_OVER_FRAMES
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             frame,
    input  logic             btn_start,
    input  logic             hit,
    output logic [1:0]       state,
    output logic             run,
    output logic             respawn,
    output logic [1:0]       lives,
    output logic [BCD_W-1:0] score,
    output logic [BCD_W-1:0] hiscore,
    output logic             new_hi
);

    localparam int DIV_W   = cnt_w(SCORE_DIV);
    localparam int DWELL_W = cnt_w((DYING_FRAMES > OVER_FRAMES) ? DYING_FRAMES : OVER_FRAMES);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCORE_DIV - 1);
    localparam logic [DWELL_W-1:0] DYING_LAST = DWELL_W'(DYING_FRAMES - 1);
    localparam logic [DWELL_W-1:0] OVER_LAST  = DWELL_W'(OVER_FRAMES - 1);
    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

    game_state_t        state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               hit_q, hit_d;
    logic               start_q;
    logic               run_d, respawn_d, new_hi_d;
    logic [1:0]         lives_d;
    logic [BCD_W-1:0]   hiscore_d;
    logic               score_clr, score_en;
    logic               start_edge, hit_any;

    // Rising edge of the button as seen frame to frame.
    assign start_edge = frame & btn_start & ~start_q;
    // A hit on the frame cycle itself counts alongside any earlier one.
    assign hit_any    = hit_q | hit;
    assign state      = state_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        dwell_d   = dwell_q;
        lives_d   = lives;
        hiscore_d = hiscore;
        new_hi_d  = new_hi;
        respawn_d = 1'b0;
        score_clr = 1'b0;
        score_en  = 1'b0;

        // Collisions latch only while playing and are consumed every frame.
        hit_d = 1'b0;
        if (state_q == ST_PLAY) begin
            hit_d = frame ? 1'b0 : hit_any;
        end

        if (frame) begin
            case (state_q)
                ST_ATTRACT, ST_OVER: begin
                    // Start wins over the game-over timeout.
                    if (start_edge) begin
                        state_d   = ST_PLAY;
                        lives_d   = LIVES_INIT;
                        score_clr = 1'b1;
                        new_hi_d  = 1'b0;
                        div_d     = '0;
                        respawn_d = 1'b1;
                    end else if (state_q == ST_OVER) begin
                        if (dwell_q == OVER_LAST) begin
                            state_d = ST_ATTRACT;
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    // A collision suppresses the score tick of the same frame.
                    if (hit_any) begin
                        state_d = ST_DYING;
                        lives_d = lives - 2'd1;
                        dwell_d = '0;
                    end else if (div_q == DIV_LAST) begin
                        div_d    = '0;
                        score_en = 1'b1;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_DYING: begin
                    if (dwell_q == DYING_LAST) begin
                        if (lives == 2'd0) begin
                            state_d = ST_OVER;
                            dwell_d = '0;
                            // BCD orders the same as binary, so a plain compare works.
                            if (score > hiscore) begin
                                hiscore_d = score;
                                new_hi_d  = 1'b1;
                            end
                        end else begin
                            state_d   = ST_PLAY;
                            respawn_d = 1'b1;
                            div_d     = '0;
                        end
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
                default: ;
            endcase
        end

        run_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q <= ST_ATTRACT;
            div_q   <= '0;
            dwell_q <= '0;
            hit_q   <= 1'b0;
            start_q <= 1'b0;
            run     <= 1'b0;
            respawn <= 1'b0;
            lives   <= 2'd0;
            hiscore <= '0;
            new_hi  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dwell_q <= dwell_d;
            hit_q   <= hit_d;
            run     <= run_d;
            respawn <= respawn_d;
            lives   <= lives_d;
            hiscore <= hiscore_d;
            new_hi  <= new_hi_d;
            if (frame) begin
                start_q <= btn_start;
            end
        end
    end

    bcd_counter4 u_score (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .clr     (score_clr),
        .en      (score_en),
        .count   (score)
    );

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl with a frame-level reference model.
module tb_game_ctrl;

    localparam int LIVES        = 3;
    localparam int SCORE_DIV    = 4;
    localparam int DYING_FRAMES = 3;
    localparam int OVER_FRAMES  = 5;

    localparam int M_ATTRACT = 0;
    localparam int M_PLAY    = 1;
    localparam int M_DYING   = 2;
    localparam int M_OVER    = 3;

    logic        clk_pix = 1'b0;
    logic        rst_pix = 1'b1;
    logic        frame = 1'b0;
    logic        btn_start = 1'b0;
    logic        hit = 1'b0;
    logic [1:0]  state;
    logic        run;
    logic        respawn;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [15:0] hiscore;
    logic        new_hi;

    logic [38:0] dut_vec;
    assign dut_vec = {state, run, respawn, lives, score, hiscore, new_hi};

    int n_checks = 0;
    int n_pass   = 0;

    game_ctrl #(
        .LIVES        (LIVES),
        .SCORE_DIV    (SCORE_DIV),
        .DYING_FRAMES (DYING_FRAMES),
        .OVER_FRAMES  (OVER_FRAMES)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_pix   (rst_pix),
        .frame     (frame),
        .btn_start (btn_start),
        .hit       (hit),
        .state     (state),
        .run       (run),
        .respawn   (respawn),
        .lives     (lives),
        .score     (score),
        .hiscore   (hiscore),
        .new_hi    (new_hi)
    );

    always #5 clk_pix = ~clk_pix;

    // Watch for respawn held high on two consecutive cycles.
    logic prev_respawn = 1'b0;
    int   respawn_double = 0;
    always @(negedge clk_pix) begin
        if (respawn === 1'b1 && prev_respawn) respawn_double <= respawn_double + 1;
        prev_respawn <= (respawn === 1'b1);
    end

    // ---------------- reference model (frame-level game rules) -------------
    int m_state = M_ATTRACT;
    int m_lives = 0;
    int m_score = 0;   // decimal points
    int m_hi    = 0;
    int m_phase = 0;   // frames elapsed in the current play/dwell period
    bit m_new_hi = 0;
    bit m_respawn = 0;
    bit m_hit_seen = 0;
    bit m_prev_btn = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [38:0] model_vec();
        return {2'(m_state), (m_state == M_PLAY), m_respawn, 2'(m_lives),
                to_bcd(m_score), to_bcd(m_hi), m_new_hi};
    endfunction

    task automatic model_new_game();
        m_state   = M_PLAY;
        m_lives   = LIVES;
        m_score   = 0;
        m_new_hi  = 0;
        m_phase   = 0;
        m_respawn = 1;
    endtask

    task automatic model_edge(input bit f, input bit b, input bit h, input bit r);
        bit start;
        if (r) begin
            m_state = M_ATTRACT; m_lives = 0; m_score = 0; m_hi = 0; m_phase = 0;
            m_new_hi = 0; m_respawn = 0; m_hit_seen = 0; m_prev_btn = 0;
            return;
        end
        m_respawn = 0;
        if (m_state == M_PLAY && h) m_hit_seen = 1;
        if (!f) return;
        start      = b && !m_prev_btn;
        m_prev_btn = b;
        case (m_state)
            M_ATTRACT: if (start) model_new_game();
            M_PLAY: begin
                if (m_hit_seen) begin
                    m_lives = m_lives - 1;
                    m_state = M_DYING;
                    m_phase = 0;
                end else begin
                    m_phase = m_phase + 1;
                    if (m_phase % SCORE_DIV == 0 && m_score < 9999) m_score = m_score + 1;
                end
            end
            M_DYING: begin
                m_phase = m_phase + 1;
                if (m_phase == DYING_FRAMES) begin
                    m_phase = 0;
                    if (m_lives == 0) begin
                        m_state = M_OVER;
                        if (m_score > m_hi) begin
                            m_hi = m_score;
                            m_new_hi = 1;
                        end
                    end else begin
                        m_state = M_PLAY;
                        m_respawn = 1;
                    end
                end
            end
            default: begin
                if (start) begin
                    model_new_game();
                end else begin
                    m_phase = m_phase + 1;
                    if (m_phase == OVER_FRAMES) m_state = M_ATTRACT;
                end
            end
        endcase
        m_hit_seen = 0;
    endtask

    // ---------------- stimulus helpers ------------------------------------
    // Drive one clock cycle; outputs are settled 1 time unit after the edge.
    task automatic cycle(input bit f, input bit b, input bit h, input bit r);
        frame = f; btn_start = b; hit = h; rst_pix = r;
        @(posedge clk_pix);
        model_edge(f, b, h, r);
        #1;
    endtask

    // A random-length gap of non-frame cycles followed by one frame cycle.
    task automatic frame_step(input bit b, input bit hit_mid, input bit hit_frame);
        int gap = $urandom_range(1, 3);
        int hit_at = $urandom_range(0, gap - 1);
        for (int i = 0; i < gap; i++) cycle(1'b0, b, hit_mid && (i == hit_at), 1'b0);
        cycle(1'b1, b, hit_frame, 1'b0);
    endtask

    task automatic play_frames(input int n);
        for (int i = 0; i < n; i++) frame_step(1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- tests -----------------------------------------------
    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (dut_vec !== 39'd0) $display("FAIL reset_outputs: got %h expected %h", dut_vec, 39'd0);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== model_vec()) $display("FAIL reset_idle: got %h expected %h", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_start();
        frame_step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({state, run, respawn, lives, score} !== {2'd1, 1'b1, 1'b1, 2'd3, 16'h0000})
            $display("FAIL start_enter_play: got %h expected %h",
                     {state, run, respawn, lives, score}, {2'd1, 1'b1, 1'b1, 2'd3, 16'h0000});
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (respawn !== 1'b0) $display("FAIL respawn_one_cycle: got %b expected 0", respawn);
        else n_pass++;
        frame_step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({state, respawn, lives} !== {2'd1, 1'b0, 2'd3})
            $display("FAIL no_second_start: got %h expected %h", {state, respawn, lives}, {2'd1, 1'b0, 2'd3});
        else n_pass++;
    endtask

    task automatic test_score_basic();
        play_frames(12);
        n_checks++;
        if (score !== 16'h0003) $display("FAIL score_12_frames: got %h expected 0003", score);
        else n_pass++;
        n_checks++;
        if (dut_vec !== model_vec()) $display("FAIL score_model: got %h expected %h", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_hit_on_tick();
        play_frames(2);
        frame_step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({state, run, lives, score} !== {2'd2, 1'b0, 2'd2, 16'h0003})
            $display("FAIL hit_on_tick: got %h expected %h", {state, run, lives, score}, {2'd2, 1'b0, 2'd2, 16'h0003});
        else n_pass++;
        play_frames(2);
        n_checks++;
        if (state !== 2'd2) $display("FAIL dying_dwell: got %0d expected 2", state);
        else n_pass++;
        play_frames(1);
        n_checks++;
        if ({state, respawn, lives, run} !== {2'd1, 1'b1, 2'd2, 1'b1})
            $display("FAIL dying_to_play: got %h expected %h", {state, respawn, lives, run}, {2'd1, 1'b1, 2'd2, 1'b1});
        else n_pass++;
    endtask

    task automatic test_game_over();
        play_frames(8);
        frame_step(1'b0, 1'b0, 1'b1);
        play_frames(3);
        frame_step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({state, lives, score} !== {2'd2, 2'd0, 16'h0005})
            $display("FAIL last_life_lost: got %h expected %h", {state, lives, score}, {2'd2, 2'd0, 16'h0005});
        else n_pass++;
        play_frames(3);
        n_checks++;
        if ({state, hiscore, new_hi, score} !== {2'd3, 16'h0005, 1'b1, 16'h0005})
            $display("FAIL over_new_hi: got %h expected %h", {state, hiscore, new_hi, score}, {2'd3, 16'h0005, 1'b1, 16'h0005});
        else n_pass++;
        play_frames(4);
        n_checks++;
        if (state !== 2'd3) $display("FAIL over_dwell: got %0d expected 3", state);
        else n_pass++;
        play_frames(1);
        n_checks++;
        if ({state, run, score, hiscore} !== {2'd0, 1'b0, 16'h0005, 16'h0005})
            $display("FAIL over_timeout: got %h expected %h", {state, run, score, hiscore}, {2'd0, 1'b0, 16'h0005, 16'h0005});
        else n_pass++;
    endtask

    task automatic test_over_start_priority();
        frame_step(1'b1, 1'b0, 1'b0);
        play_frames(28);
        for (int k = 0; k < 3; k++) begin
            frame_step(1'b0, 1'b1, 1'b0);
            play_frames(3);
        end
        n_checks++;
        if ({state, hiscore, new_hi} !== {2'd3, 16'h0007, 1'b1})
            $display("FAIL second_over: got %h expected %h", {state, hiscore, new_hi}, {2'd3, 16'h0007, 1'b1});
        else n_pass++;
        play_frames(4);
        frame_step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({state, respawn, lives, score, hiscore, new_hi} !== {2'd1, 1'b1, 2'd3, 16'h0000, 16'h0007, 1'b0})
            $display("FAIL start_beats_timeout: got %h expected %h", {state, respawn, lives, score, hiscore, new_hi},
                     {2'd1, 1'b1, 2'd3, 16'h0000, 16'h0007, 1'b0});
        else n_pass++;
    endtask

    task automatic test_reset_mid_game();
        play_frames(36);
        n_checks++;
        if (score !== 16'h0009) $display("FAIL pre_reset_score: got %h expected 0009", score);
        else n_pass++;
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (dut_vec !== 39'd0) $display("FAIL reset_mid_play: got %h expected %h", dut_vec, 39'd0);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random_play();
        for (int i = 0; i < 400; i++) begin
            int gap = $urandom_range(0, 3);
            bit b = ($urandom_range(0, 3) == 0);
            for (int g = 0; g < gap; g++) cycle(1'b0, b, ($urandom_range(0, 5) == 0), 1'b0);
            cycle(1'b1, b, ($urandom_range(0, 9) == 0), 1'b0);
            n_checks++;
            if (dut_vec !== model_vec())
                $display("FAIL random_frame_%0d: got %h expected %h", i, dut_vec, model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_score_rollover();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 396; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (score !== 16'h0099) $display("FAIL score_0099: got %h expected 0099", score);
        else n_pass++;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (score !== 16'h0100) $display("FAIL score_carry_0100: got %h expected 0100", score);
        else n_pass++;
        for (int i = 0; i < 39596; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (score !== 16'h9999) $display("FAIL score_9999: got %h expected 9999", score);
        else n_pass++;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (score !== 16'h9999) $display("FAIL score_saturate: got %h expected 9999", score);
        else n_pass++;
        n_checks++;
        if (dut_vec !== model_vec()) $display("FAIL saturate_model: got %h expected %h", dut_vec, model_vec());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_score_basic();
        test_hit_on_tick();
        test_game_over();
        test_over_start_priority();
        test_reset_mid_game();
        test_random_play();
        test_score_rollover();
        n_checks++;
        if (respawn_double !== 0) $display("FAIL respawn_pulse_width: got %0d double pulses expected 0", respawn_double);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES, default 3: lives granted per game (1..3).
REQ-002 Parameter SCORE_DIV, default 60: PLAY frames per score point.
REQ-003 Parameter DYING_FRAMES, default 120: frames spent in DYING.
REQ-004 Parameter OVER_FRAMES, default 600: frames in OVER before returning to ATTRACT.
REQ-005 clk_pix  in  1  pixel clock; the only clock.
REQ-006 rst_pix  in  1  reset, synchronous, active-high.
REQ-007 frame  in  1  one-cycle pulse at start of frame.
REQ-008 btn_start  in  1  start button level.
REQ-009 hit  in  1  player/obstacle collision level, any cycle.
REQ-010 state  out  2  current state encoding.
REQ-011 run  out  1  high when sprite motion is enabled.
REQ-012 respawn  out  1  one-cycle pulse that resets player and obstacle positions.
REQ-013 lives  out  2  remaining lives.
REQ-014 score  out  16  4-digit BCD score.
REQ-015 hiscore  out  16  4-digit BCD best score.
REQ-016 new_hi  out  1  high when the last game set a new hiscore.

Function
REQ-017 States SHALL be ATTRACT=0, PLAY=1, DYING=2, OVER=3; transitions SHALL occur only on cycles with frame=1; all outputs SHALL be registered and change on the clock edge that ends that cycle.
REQ-018 btn_start SHALL be sampled only on frame cycles; start_edge = sample high AND previous frame-sample low.
REQ-019 In PLAY, hit SHALL set sticky hit_q on any cycle; hit_q SHALL clear on every frame cycle; hit asserted on the frame cycle itself SHALL count.
REQ-020 In states other than PLAY, hit SHALL be ignored and hit_q held at 0.
REQ-021 ATTRACT: run=0; on start_edge -> PLAY, lives<=LIVES, score<=0, new_hi<=0, frame divider<=0, respawn=1 for one cycle.
REQ-022 PLAY: run=1; per frame, divider increments; on reaching SCORE_DIV-1 it wraps to 0 and score increments by 1 in BCD.
REQ-023 Score SHALL saturate at 9999; BCD digits SHALL carry 9->0 into the next digit.
REQ-024 PLAY with (hit_q OR hit) on a frame cycle -> DYING, lives<=lives-1, dwell counter<=0; no score increment on that frame (hit wins).
REQ-025 DYING: run=0; dwell increments per frame; on the frame where dwell=DYING_FRAMES-1: lives=0 -> OVER, else -> PLAY with respawn pulse and divider<=0.
REQ-026 On entry to OVER: if score>hiscore then hiscore<=score and new_hi<=1; dwell<=0.
REQ-027 OVER: run=0; start_edge -> PLAY exactly as from ATTRACT; otherwise, at dwell=OVER_FRAMES-1 -> ATTRACT; start_edge takes priority over timeout.
REQ-028 respawn SHALL never be asserted for more than one consecutive cycle.
REQ-029 Score and lives SHALL hold their values in DYING, OVER and ATTRACT.

Reset
REQ-030 On rst_pix, the following SHALL apply on the next edge, regardless of state or of a simultaneous frame: state=ATTRACT, run=0, respawn=0, lives=0, score=0, hiscore=0, new_hi=0, all counters=0, hit_q=0, start sample=0.
REQ-031 Reset mid-game SHALL discard the score without updating hiscore.

Structure
REQ-032 Shared package game_pkg SHALL hold the state typedef and encodings, the BCD width constant (16), and the default LIVES/SCORE_DIV/DYING_FRAMES/OVER_FRAMES values.
REQ-033 One sub-module, bcd_counter4, SHALL implement the 4-digit saturating BCD increment with clear and enable inputs.
REQ-034 Frame divider and dwell counters SHALL be sized by $clog2 of their parameters.

Verification (bench params SCORE_DIV=4, DYING_FRAMES=3, OVER_FRAMES=5, LIVES=3)
REQ-035 Reset, btn_start high across 2 frames -> one respawn pulse, state=PLAY, lives=3, score=0, run=1; no second start.
REQ-036 Play 12 frames without hit -> score=0x0003; preload near 0x0099 -> next point gives 0x0100; at 0x9999 -> stays 0x9999.
REQ-037 One-cycle hit mid-frame on the same frame as a score tick -> DYING, lives=2, score unchanged; after 3 frames -> PLAY with respawn.
REQ-038 Three hits -> lives=0, OVER after 3 DYING frames; score 0x0005 > hiscore 0 -> hiscore=0x0005, new_hi=1; no start -> ATTRACT after 5 frames.
REQ-039 In OVER, start_edge on the timeout frame -> PLAY (not ATTRACT), new_hi=0, hiscore retained.
REQ-040 rst_pix asserted mid-PLAY coincident with frame and hit -> all outputs at reset values next cycle, hiscore=0.
